// File: rtl/alu_sweep_checker.sv
// alu_sweep_checker
//   Walks every operand pair of a 4-bit ALU tile through all nine function
//   slots and checks the ALU's 7-segment and flag outputs against a
//   locally computed result.
//   Vector index = slot*256 + A*16 + B  (0x000 .. 0x8FF).
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   ena              1 = run, 0 = freeze every register
//   start            level; begins a sweep when sampled in IDLE or DONE
//   seg_in[6:0]      segment pattern returned by the ALU
//   flags_in[3:0]    {Z, N, C, V} returned by the ALU
//   op_a/op_b/op_func  registered operands and function code to the ALU
//   busy             high in SETTLE / SAMPLE
//   done             high in DONE
//   err_count[11:0]  failing vectors in the current / last sweep
//   fail             sticky, set by the first failing vector
//   first_fail_idx   index of the first failing vector (valid when fail)
//
// Handshake: there is no valid/ready pair. The checker owns op_* and
// treats seg_in/flags_in as settled SETTLE_CYC cycles after op_* change.
module alu_sweep_checker #(
    parameter int SETTLE_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  flags_in,
    output logic [3:0]  op_a,
    output logic [3:0]  op_b,
    output logic [3:0]  op_func,
    output logic        busy,
    output logic        done,
    output logic [11:0] err_count,
    output logic        fail,
    output logic [11:0] first_fail_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [11:0] LAST_IDX   = 12'h8FF;
    localparam logic [3:0]  SETTLE_END = 4'(SETTLE_CYC - 1);

    state_t      state, state_nxt;
    logic [11:0] idx;
    logic [11:0] idx_nxt;
    logic [3:0]  cnt;
    logic        start_sweep;
    logic        last_vec;

    function automatic logic [3:0] slot_func(input logic [3:0] slot);
        case (slot)
            4'd0:    slot_func = 4'b0000;
            4'd1:    slot_func = 4'b0001;
            4'd2:    slot_func = 4'b0100;
            4'd3:    slot_func = 4'b0101;
            4'd4:    slot_func = 4'b0110;
            4'd5:    slot_func = 4'b1000;
            4'd6:    slot_func = 4'b1001;
            4'd7:    slot_func = 4'b1010;
            4'd8:    slot_func = 4'b1111;
            default: slot_func = 4'b0000;
        endcase
    endfunction

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        start_sweep = 1'b0;
        last_vec    = (idx == LAST_IDX);
        idx_nxt     = idx + 12'd1;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt   = SETTLE;
                    start_sweep = 1'b1;
                end
            end
            SETTLE: if (cnt == SETTLE_END) state_nxt = SAMPLE;
            SAMPLE: state_nxt = last_vec ? DONE : SETTLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Expected result for the vector currently on op_*
    // ---------------------------------------------------------------
    logic [3:0] slot;
    logic [3:0] b_eff;
    logic       cin;
    logic [4:0] sum5;
    logic [3:0] r_exp;
    logic       c_exp, v_exp, z_exp, n_exp;
    logic [3:0] dig;
    logic       dig_valid, seg_blank;
    logic       seg_ok, flag_ok, vec_fail;

    always_comb begin
        slot  = idx[11:8];
        cin   = (slot == 4'd1);
        b_eff = cin ? ~op_b : op_b;
        sum5  = {1'b0, op_a} + {1'b0, b_eff} + {4'b0000, cin};
        c_exp = sum5[4];
        // Carry into bit 3 is recovered from the bit-3 sum and operands.
        v_exp = (op_a[3] ^ b_eff[3] ^ sum5[3]) ^ c_exp;

        case (slot)
            4'd0, 4'd1: r_exp = sum5[3:0];
            4'd2:       r_exp = op_a & op_b;
            4'd3:       r_exp = op_a | op_b;
            4'd4:       r_exp = op_a ^ op_b;
            4'd5:       r_exp = {op_a[2:0], 1'b0};
            4'd6:       r_exp = {1'b0, op_a[3:1]};
            4'd7:       r_exp = {op_a[3], op_a[3:1]};
            4'd8:       r_exp = op_a;
            default:    r_exp = 4'd0;
        endcase
        z_exp = (r_exp == 4'd0);
        n_exp = r_exp[3];

        dig       = 4'd0;
        dig_valid = 1'b1;
        seg_blank = 1'b0;
        case (seg_in)
            7'b0111111: dig = 4'd0;
            7'b0000110: dig = 4'd1;
            7'b1011011: dig = 4'd2;
            7'b1001111: dig = 4'd3;
            7'b1100110: dig = 4'd4;
            7'b1101101: dig = 4'd5;
            7'b1111100: dig = 4'd6;
            7'b0000111: dig = 4'd7;
            7'b1111111: dig = 4'd8;
            7'b1100111: dig = 4'd9;
            7'b0000000: begin
                dig_valid = 1'b0;
                seg_blank = 1'b1;
            end
            default:    dig_valid = 1'b0;
        endcase

        // An invalid pattern is neither a digit nor blank, so it fails
        // whichever branch applies.
        seg_ok  = (r_exp <= 4'd9) ? (dig_valid && (dig == r_exp)) : seg_blank;
        flag_ok = (flags_in[3] == z_exp) && (flags_in[2] == n_exp) &&
                  ((slot >= 4'd2) ||
                   ((flags_in[1] == c_exp) && (flags_in[0] == v_exp)));
        vec_fail = !(seg_ok && flag_ok);
    end

    // ---------------------------------------------------------------
    // State, vector and result registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= 12'd0;
            cnt            <= 4'd0;
            op_a           <= 4'd0;
            op_b           <= 4'd0;
            op_func        <= 4'd0;
            err_count      <= 12'd0;
            fail           <= 1'b0;
            first_fail_idx <= 12'd0;
        end else if (ena) begin
            state <= state_nxt;
            if (start_sweep) begin
                idx            <= 12'd0;
                cnt            <= 4'd0;
                op_a           <= 4'd0;
                op_b           <= 4'd0;
                op_func        <= slot_func(4'd0);
                err_count      <= 12'd0;
                fail           <= 1'b0;
                first_fail_idx <= 12'd0;
            end else if (state == SETTLE) begin
                if (cnt != SETTLE_END) cnt <= cnt + 4'd1;
            end else if (state == SAMPLE) begin
                cnt <= 4'd0;
                if (vec_fail) begin
                    err_count <= err_count + 12'd1;
                    if (!fail) begin
                        fail           <= 1'b1;
                        first_fail_idx <= idx;
                    end
                end
                // On the last vector idx and op_* hold through DONE.
                if (!last_vec) begin
                    idx     <= idx_nxt;
                    op_a    <= idx_nxt[7:4];
                    op_b    <= idx_nxt[3:0];
                    op_func <= slot_func(idx_nxt[11:8]);
                end
            end
        end
    end

    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);

endmodule
